// File: rtl/operand_driver_pkg.sv
// Shared types, constants and the corner-value table for operand_driver.
package operand_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RANDOM = 2'd1,
        ST_CORNER = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        MODE_RANDOM = 1'b0,
        MODE_CORNER = 1'b1
    } mode_t;

    localparam int NUM_CORNERS     = 5;
    localparam int NUM_CORNER_VECS = 25;

    typedef logic [2:0] corner_idx_t;
    typedef logic [4:0] vec_idx_t;

    localparam corner_idx_t LAST_CORNER = corner_idx_t'(NUM_CORNERS - 1);
    localparam vec_idx_t    LAST_VEC    = vec_idx_t'(NUM_CORNER_VECS - 1);

    // Corner table: 0, 1, max signed, min signed, all ones. Computed at 64 bits;
    // callers truncate to their width. For width 64 the all-ones case wraps
    // through zero, which still yields all ones.
    function automatic logic [63:0] corner_value(input corner_idx_t idx, input int width);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        case (idx)
            3'd0:    corner_value = 64'd0;
            3'd1:    corner_value = 64'd1;
            3'd2:    corner_value = msb - 64'd1;
            3'd3:    corner_value = msb;
            default: corner_value = (msb << 1) - 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/operand_driver_delay_line.sv
// Fixed-depth shift register; every stage clears on reset and shifts every cycle.
module delay_line #(
    parameter int DATA_W = 1,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] delayed
);

    logic [DATA_W-1:0] stage [DEPTH];

    // Shift chain: stage 0 takes the input, each later stage takes its predecessor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/operand_driver.sv
// Operand source for the arithmetic bench: LFSR pass-through or a 5x5 corner
// sweep, with a latency-matched copy for the monitor.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for i_start; outputs held, valid low
// ST_RANDOM | pass LFSR operands through whenever i_rand_valid is high
// ST_CORNER | issue one corner vector per cycle, 25 in total
// ST_DONE   | sweep finished; o_done fires on the following cycle
module operand_driver
    import operand_driver_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_mode,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_rand_a,
    input  logic [WIDTH-1:0] i_rand_b,
    input  logic             i_rand_valid,
    output logic [WIDTH-1:0] o_drive_a,
    output logic [WIDTH-1:0] o_drive_b,
    output logic             o_drive_valid,
    output logic [WIDTH-1:0] o_drive_delayed_a,
    output logic [WIDTH-1:0] o_drive_delayed_b,
    output logic             o_delayed_valid,
    output logic             o_done,
    output logic [31:0]      o_vec_count
);

    state_t      state;
    state_t      state_nxt;
    logic        accept_start;
    logic        load_random;
    logic        load_corner;
    corner_idx_t row;
    corner_idx_t col;
    vec_idx_t    vec_idx;
    logic [31:0] vec_count;
    logic [WIDTH-1:0] corner_a;
    logic [WIDTH-1:0] corner_b;
    logic [2*WIDTH:0] delay_in;
    logic [2*WIDTH:0] delay_out;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and load strobes; i_stop takes priority over everything else.
    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        load_random  = 1'b0;
        load_corner  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    accept_start = 1'b1;
                    state_nxt    = (mode_t'(i_mode) == MODE_CORNER) ? ST_CORNER : ST_RANDOM;
                end
            end
            ST_RANDOM: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    load_random = i_rand_valid;
                end
            end
            ST_CORNER: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    load_corner = 1'b1;
                    if (vec_idx == LAST_VEC) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Corner operands for the current row (a) and column (b).
    always_comb begin
        corner_a = WIDTH'(corner_value(row, WIDTH));
        corner_b = WIDTH'(corner_value(col, WIDTH));
    end

    // Drive registers; operands hold whenever nothing is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_drive_a     <= '0;
            o_drive_b     <= '0;
            o_drive_valid <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_drive_valid <= load_random | load_corner;
            o_done        <= (state == ST_DONE);
            if (load_random) begin
                o_drive_a <= i_rand_a;
                o_drive_b <= i_rand_b;
            end else if (load_corner) begin
                o_drive_a <= corner_a;
                o_drive_b <= corner_b;
            end
        end
    end

    // Corner sweep position: vec_idx ends the run, row/col address the table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            vec_idx <= '0;
        end else if (accept_start) begin
            row     <= '0;
            col     <= '0;
            vec_idx <= '0;
        end else if (load_corner) begin
            vec_idx <= vec_idx + 5'd1;
            if (col == LAST_CORNER) begin
                col <= '0;
                row <= row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

    // Saturating count of vectors driven since the last accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_count <= '0;
        end else if (accept_start) begin
            vec_count <= '0;
        end else if ((load_random || load_corner) && (vec_count != 32'hFFFF_FFFF)) begin
            vec_count <= vec_count + 32'd1;
        end
    end

    assign o_vec_count = vec_count;
    assign delay_in    = {o_drive_a, o_drive_b, o_drive_valid};

    delay_line #(
        .DATA_W (2*WIDTH + 1),
        .DEPTH  (LATENCY)
    ) u_delay_line (
        .clk     (clk),
        .reset   (reset),
        .data    (delay_in),
        .delayed (delay_out)
    );

    assign {o_drive_delayed_a, o_drive_delayed_b, o_delayed_valid} = delay_out;

endmodule

// File: tb/tb_operand_driver.sv
// Bench for operand_driver: an 8-bit/latency-1 and a 32-bit/latency-4 instance
// share stimulus and are compared every cycle against a run-level model.
module tb_operand_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode, start, stop, rv;
    logic [31:0] ra, rb;

    logic [7:0]  a8, b8, da8, db8;
    logic        v8, dv8, done8;
    logic [31:0] cnt8;
    logic [31:0] a32, b32, da32, db32;
    logic        v32, dv32, done32;
    logic [31:0] cnt32;

    int n_vec  = 0;
    int n_miss = 0;
    int done_pulses8 = 0;

    always #5 clk = ~clk;

    operand_driver #(.WIDTH(8), .LATENCY(1)) dut8 (
        .clk(clk), .reset(reset), .i_mode(mode), .i_start(start), .i_stop(stop),
        .i_rand_a(ra[7:0]), .i_rand_b(rb[7:0]), .i_rand_valid(rv),
        .o_drive_a(a8), .o_drive_b(b8), .o_drive_valid(v8),
        .o_drive_delayed_a(da8), .o_drive_delayed_b(db8), .o_delayed_valid(dv8),
        .o_done(done8), .o_vec_count(cnt8)
    );

    operand_driver #(.WIDTH(32), .LATENCY(4)) dut32 (
        .clk(clk), .reset(reset), .i_mode(mode), .i_start(start), .i_stop(stop),
        .i_rand_a(ra), .i_rand_b(rb), .i_rand_valid(rv),
        .o_drive_a(a32), .o_drive_b(b32), .o_drive_valid(v32),
        .o_drive_delayed_a(da32), .o_drive_delayed_b(db32), .o_delayed_valid(dv32),
        .o_done(done32), .o_vec_count(cnt32)
    );

    // Reference model, one slot per instance (0: 8-bit, 1: 32-bit).
    // run: 0 idle, 1 random, 2 corner sweep, 3 sweep finished.
    int          m_run [2];
    int          m_k   [2];
    logic [63:0] m_a   [2];
    logic [63:0] m_b   [2];
    logic        m_v   [2];
    logic        m_done[2];
    logic [31:0] m_cnt [2];
    logic [63:0] h_a   [2][16];
    logic [63:0] h_b   [2][16];
    logic        h_v   [2][16];
    logic [63:0] m_da  [2];
    logic [63:0] m_db  [2];
    logic        m_dv  [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] width_mask(input int wd);
        return (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wd) - 64'd1);
    endfunction

    // Corner i of a wd-bit operand: 0, 1, 2^(wd-1)-1, 2^(wd-1), 2^wd-1.
    function automatic logic [63:0] corner_ref(input int i, input int wd);
        case (i)
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return (64'd1 << (wd - 1)) - 64'd1;
            3:       return 64'd1 << (wd - 1);
            default: return width_mask(wd);
        endcase
    endfunction

    task automatic model_reset();
        for (int idx = 0; idx < 2; idx++) begin
            m_run[idx] = 0; m_k[idx] = 0;
            m_a[idx] = '0; m_b[idx] = '0; m_v[idx] = 1'b0; m_done[idx] = 1'b0;
            m_cnt[idx] = '0; m_da[idx] = '0; m_db[idx] = '0; m_dv[idx] = 1'b0;
            for (int j = 0; j < 16; j++) begin
                h_a[idx][j] = '0; h_b[idx][j] = '0; h_v[idx][j] = 1'b0;
            end
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step(input int idx);
        int          wd;
        int          lat;
        logic [63:0] mask;
        wd   = (idx == 0) ? 8 : 32;
        lat  = (idx == 0) ? 1 : 4;
        mask = width_mask(wd);
        for (int j = 15; j > 0; j--) begin
            h_a[idx][j] = h_a[idx][j-1]; h_b[idx][j] = h_b[idx][j-1]; h_v[idx][j] = h_v[idx][j-1];
        end
        h_a[idx][0] = m_a[idx]; h_b[idx][0] = m_b[idx]; h_v[idx][0] = m_v[idx];
        m_da[idx] = h_a[idx][lat-1]; m_db[idx] = h_b[idx][lat-1]; m_dv[idx] = h_v[idx][lat-1];
        m_done[idx] = (m_run[idx] == 3);
        m_v[idx] = 1'b0;
        case (m_run[idx])
            0: if (start && !stop) begin
                m_run[idx] = mode ? 2 : 1;
                m_k[idx]   = 0;
                m_cnt[idx] = '0;
            end
            1: if (stop) m_run[idx] = 0;
               else if (rv) begin
                   m_a[idx] = {32'd0, ra} & mask;
                   m_b[idx] = {32'd0, rb} & mask;
                   m_v[idx] = 1'b1;
                   if (m_cnt[idx] != 32'hFFFF_FFFF) m_cnt[idx] = m_cnt[idx] + 1;
               end
            2: if (stop) m_run[idx] = 0;
               else begin
                   m_a[idx] = corner_ref(m_k[idx] / 5, wd);
                   m_b[idx] = corner_ref(m_k[idx] % 5, wd);
                   m_v[idx] = 1'b1;
                   if (m_cnt[idx] != 32'hFFFF_FFFF) m_cnt[idx] = m_cnt[idx] + 1;
                   if (m_k[idx] == 24) m_run[idx] = 3;
                   else m_k[idx] = m_k[idx] + 1;
               end
            default: m_run[idx] = 0;
        endcase
    endtask

    task automatic compare_all();
        check_val("w8 drive_a",     {56'd0, a8},   m_a[0]);
        check_val("w8 drive_b",     {56'd0, b8},   m_b[0]);
        check_val("w8 drive_valid", {63'd0, v8},   {63'd0, m_v[0]});
        check_val("w8 delayed_a",   {56'd0, da8},  m_da[0]);
        check_val("w8 delayed_b",   {56'd0, db8},  m_db[0]);
        check_val("w8 delayed_vld", {63'd0, dv8},  {63'd0, m_dv[0]});
        check_val("w8 done",        {63'd0, done8}, {63'd0, m_done[0]});
        check_val("w8 vec_count",   {32'd0, cnt8}, {32'd0, m_cnt[0]});
        check_val("w32 drive_a",     {32'd0, a32},  m_a[1]);
        check_val("w32 drive_b",     {32'd0, b32},  m_b[1]);
        check_val("w32 drive_valid", {63'd0, v32},  {63'd0, m_v[1]});
        check_val("w32 delayed_a",   {32'd0, da32}, m_da[1]);
        check_val("w32 delayed_b",   {32'd0, db32}, m_db[1]);
        check_val("w32 delayed_vld", {63'd0, dv32}, {63'd0, m_dv[1]});
        check_val("w32 done",        {63'd0, done32}, {63'd0, m_done[1]});
        check_val("w32 vec_count",   {32'd0, cnt32}, {32'd0, m_cnt[1]});
    endtask

    // Advance one clock: model on the edge, compare on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        if (done8) done_pulses8++;
        compare_all();
    endtask

    task automatic randomize_data();
        rv = 1'($urandom);
        ra = $urandom;
        rb = $urandom;
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; start = 1'b0; stop = 1'b0; rv = 1'b0; ra = '0; rb = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Full corner sweep with noise on the LFSR inputs and i_mode.
        done_pulses8 = 0;
        mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 28; i++) begin
            randomize_data();
            mode = 1'($urandom);
            tick();
        end
        check_val("w8 corner total",  {32'd0, cnt8},  64'd25);
        check_val("w32 corner total", {32'd0, cnt32}, 64'd25);
        check_val("w8 done pulses",   64'(done_pulses8), 64'd1);

        // Random mode with the valid pattern 1,0,1.
        mode = 1'b0; rv = 1'b0; start = 1'b1; tick(); start = 1'b0;
        ra = 32'hDEAD_BEEF; rb = 32'h1234_5678; rv = 1'b1; tick();
        ra = $urandom;      rb = $urandom;      rv = 1'b0; tick();
        ra = 32'hDEAD_BEEF; rb = 32'h1234_5678; rv = 1'b1; tick();
        rv = 1'b0;
        repeat (5) tick();
        check_val("w32 random total", {32'd0, cnt32}, 64'd2);

        // Random traffic; starts and mode changes mid-run must be ignored.
        for (int i = 0; i < 60; i++) begin
            randomize_data();
            mode  = 1'($urandom);
            start = 1'($urandom);
            tick();
        end
        start = 1'b0; stop = 1'b1; tick(); stop = 1'b0; tick();

        // Corner sweep aborted once vector 10 is on the outputs, then restarted.
        done_pulses8 = 0;
        mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
        repeat (11) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        repeat (3) tick();
        check_val("w8 abort count", {32'd0, cnt8}, 64'd11);
        check_val("w8 abort done",  64'(done_pulses8), 64'd0);
        start = 1'b1; tick(); start = 1'b0; tick();
        check_val("w8 restart a", {56'd0, a8}, 64'd0);
        check_val("w8 restart b", {56'd0, b8}, 64'd0);
        repeat (28) tick();

        // Start and stop together in IDLE: nothing starts.
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        rv = 1'b1; tick(); tick();
        check_val("w8 start+stop valid", {63'd0, v8}, 64'd0);

        // Mixed random control traffic across all states.
        for (int i = 0; i < 300; i++) begin
            randomize_data();
            mode  = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            tick();
        end
        start = 1'b0; stop = 1'b1; tick(); stop = 1'b0;

        // Saturation: preload the counter near its limit during a random run.
        mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
        rv = 1'b1; tick();
        force dut32.vec_count = 32'hFFFF_FFFD;
        m_cnt[1] = 32'hFFFF_FFFD;
        #1;
        release dut32.vec_count;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom; rb = $urandom; rv = 1'b1;
            tick();
        end
        check_val("w32 saturated", {32'd0, cnt32}, 64'h0000_0000_FFFF_FFFF);

        // Asynchronous reset in the middle of a random run.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        compare_all();
        for (int i = 0; i < 5; i++) begin
            ra = $urandom; rb = $urandom; rv = 1'b1;
            tick();
            check_val("w32 post-reset delayed_vld", {63'd0, dv32}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
